// File: rtl/fp8_div_seq_if.sv
// Operand/result handshake bundle for the sequential FP8 divider.
// Master drives operands and out_ready; slave returns the quotient and flags.
interface fp8_div_seq_if #(
  parameter int DWIDTH = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] a_operand;
  logic [DWIDTH-1:0] b_operand;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] result;
  logic              Exception;
  logic              Overflow;
  logic              Underflow;
  logic              DivByZero;

  modport master (
    output in_valid, a_operand, b_operand, out_ready,
    input  in_ready, out_valid, result, Exception, Overflow, Underflow, DivByZero
  );

  modport slave (
    input  in_valid, a_operand, b_operand, out_ready,
    output in_ready, out_valid, result, Exception, Overflow, Underflow, DivByZero
  );
endinterface

// File: rtl/fp8_div_seq.sv
// Restoring radix-2 FP8 divider; specials in 1 edge, normals in QB+1 edges after accept.
// Result is held in DONE until out_ready; no new operands are taken until then.
module fp8_div_seq #(
  parameter int DWIDTH = 8,
  parameter int EWIDTH = 4,
  parameter int MWIDTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  fp8_div_seq_if.slave bus
);
  localparam int QB   = MWIDTH + 3;
  localparam int RW   = MWIDTH + 3;
  localparam int XW   = EWIDTH + 3;
  localparam int CW   = $clog2(QB);
  localparam int BIAS = (1 << (EWIDTH - 1)) - 1;
  localparam int EMAX = (1 << EWIDTH) - 1;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROUND, S_DONE} state_t;

  state_t                r_state, w_state;
  logic                  r_sign, w_sign;
  logic [MWIDTH:0]       r_div, w_div;
  logic [RW-1:0]         r_rem, w_rem;
  logic [QB-1:0]         r_q, w_q;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic signed [XW-1:0]  r_exp, w_exp;
  logic [DWIDTH-1:0]     r_result, w_result;
  logic                  r_exc, w_exc, r_ovf, w_ovf, r_unf, w_unf, r_dbz, w_dbz;

  logic [EWIDTH-1:0]     w_ea, w_eb;
  logic [MWIDTH-1:0]     w_ma, w_mb;
  logic                  w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_in_sign;
  logic signed [XW-1:0]  w_exp_load;

  assign w_ea      = bus.a_operand[DWIDTH-2 -: EWIDTH];
  assign w_eb      = bus.b_operand[DWIDTH-2 -: EWIDTH];
  assign w_ma      = bus.a_operand[MWIDTH-1:0];
  assign w_mb      = bus.b_operand[MWIDTH-1:0];
  assign w_a_zero  = (w_ea == '0);
  assign w_b_zero  = (w_eb == '0);
  assign w_a_inf   = &w_ea;
  assign w_b_inf   = &w_eb;
  assign w_in_sign = bus.a_operand[DWIDTH-1] ^ bus.b_operand[DWIDTH-1];
  assign w_exp_load = $signed({{(XW-EWIDTH){1'b0}}, w_ea})
                    - $signed({{(XW-EWIDTH){1'b0}}, w_eb})
                    + $signed(XW'(BIAS));

  // One restoring step: the kept remainder is stored pre-shifted for the next bit.
  logic [RW-1:0] w_trial, w_rem_keep;
  logic          w_qbit;
  assign w_trial    = r_rem - {{(RW-MWIDTH-1){1'b0}}, r_div};
  assign w_qbit     = ~w_trial[RW-1];
  assign w_rem_keep = w_qbit ? w_trial : r_rem;

  logic [MWIDTH:0]      w_sig;
  logic [MWIDTH-1:0]    w_mant;
  logic                 w_guard, w_drop, w_sticky, w_inc, w_carry;
  logic signed [XW-1:0] w_norm_e, w_e_fin;

  assign w_sig    = r_q[QB-1] ? r_q[QB-1:2] : r_q[QB-2:1];
  assign w_guard  = r_q[QB-1] ? r_q[1] : r_q[0];
  assign w_drop   = r_q[QB-1] & r_q[0];
  assign w_norm_e = r_q[QB-1] ? r_exp : r_exp - $signed(XW'(1));
  assign w_sticky = (|r_rem) | w_drop;
  assign w_inc    = w_guard & (w_sticky | w_sig[0]);
  assign w_carry  = w_inc & (&w_sig);
  assign w_mant   = w_sig[MWIDTH-1:0] + MWIDTH'(w_inc);
  assign w_e_fin  = w_norm_e + $signed({{(XW-1){1'b0}}, w_carry});

  always_comb begin
    w_state  = r_state;
    w_sign   = r_sign;
    w_div    = r_div;
    w_rem    = r_rem;
    w_q      = r_q;
    w_cnt    = r_cnt;
    w_exp    = r_exp;
    w_result = r_result;
    w_exc    = r_exc;
    w_ovf    = r_ovf;
    w_unf    = r_unf;
    w_dbz    = r_dbz;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_sign   = w_in_sign;
          w_result = '0;
          w_exc    = 1'b0;
          w_ovf    = 1'b0;
          w_unf    = 1'b0;
          w_dbz    = 1'b0;
          w_q      = '0;
          w_cnt    = '0;
          w_div    = {1'b1, w_mb};
          w_rem    = {{(RW-MWIDTH-1){1'b0}}, 1'b1, w_ma};
          w_exp    = w_exp_load;
          if (w_a_inf || w_b_inf || (w_a_zero && w_b_zero)) begin
            w_exc   = 1'b1;
            w_state = S_DONE;
          end else if (w_b_zero) begin
            w_dbz    = 1'b1;
            w_result = {w_in_sign, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
            w_state  = S_DONE;
          end else if (w_a_zero) begin
            w_result = {w_in_sign, {(DWIDTH-1){1'b0}}};
            w_state  = S_DONE;
          end else begin
            w_state = S_DIV;
          end
        end
      end
      S_DIV: begin
        w_rem = {w_rem_keep[RW-2:0], 1'b0};
        w_q   = {r_q[QB-2:0], w_qbit};
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == CW'(QB - 1)) begin
          w_cnt   = '0;
          w_state = S_ROUND;
        end
      end
      S_ROUND: begin
        w_state = S_DONE;
        if (w_e_fin >= $signed(XW'(EMAX))) begin
          w_ovf    = 1'b1;
          w_result = {r_sign, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
        end else if (w_e_fin[XW-1] || (w_e_fin == '0)) begin
          w_unf    = 1'b1;
          w_result = {r_sign, {(DWIDTH-1){1'b0}}};
        end else begin
          w_result = {r_sign, w_e_fin[EWIDTH-1:0], w_mant};
        end
      end
      S_DONE: begin
        if (bus.out_ready) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sign   <= 1'b0;
      r_div    <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_exp    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_sign   <= w_sign;
      r_div    <= w_div;
      r_rem    <= w_rem;
      r_q      <= w_q;
      r_cnt    <= w_cnt;
      r_exp    <= w_exp;
      r_result <= w_result;
      r_exc    <= w_exc;
      r_ovf    <= w_ovf;
      r_unf    <= w_unf;
      r_dbz    <= w_dbz;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.Exception = r_exc;
  assign bus.Overflow  = r_ovf;
  assign bus.Underflow = r_unf;
  assign bus.DivByZero = r_dbz;
endmodule

// File: tb/tb_fp8_div_seq.sv
// Scoreboarded random + directed bench for fp8_div_seq with an exact rational reference model.
module tb_fp8_div_seq;
  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   rdy_mode;
  bit   stim_done;

  typedef struct {
    logic [7:0] res;
    logic       exc, ovf, unf, dbz;
    int         lat;   // clock edges from the accept edge (inclusive) to out_valid rising
    int         acc;
  } exp_t;

  exp_t q[$];

  fp8_div_seq_if #(.DWIDTH(8)) bus ();

  fp8_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Exact quotient of the two significands, rounded to nearest-even on 3 fraction bits.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   ea, eb, na, nb, sh, ex, num, f, rr;
    logic s;
    ea = int'(a[6:3]);
    eb = int'(b[6:3]);
    na = 8 + int'(a[2:0]);
    nb = 8 + int'(b[2:0]);
    s  = a[7] ^ b[7];
    e.res = 8'h00; e.exc = 1'b0; e.ovf = 1'b0; e.unf = 1'b0; e.dbz = 1'b0;
    e.lat = 1; e.acc = 0;
    if (ea == 15 || eb == 15 || (ea == 0 && eb == 0)) begin
      e.exc = 1'b1;
    end else if (eb == 0) begin
      e.dbz = 1'b1;
      e.res = {s, 7'b1111000};
    end else if (ea == 0) begin
      e.res = {s, 7'b0000000};
    end else begin
      e.lat = 8;
      sh  = (na < nb) ? 1 : 0;
      ex  = ea - eb + 7 - sh;
      num = na << (3 + sh);
      f   = num / nb;
      rr  = num % nb;
      if (2 * rr > nb || (2 * rr == nb && (f % 2) == 1)) f = f + 1;
      if (f == 16) begin
        f  = 8;
        ex = ex + 1;
      end
      if (ex >= 15) begin
        e.ovf = 1'b1;
        e.res = {s, 7'b1111000};
      end else if (ex <= 0) begin
        e.unf = 1'b1;
        e.res = {s, 7'b0000000};
      end else begin
        e.res = {s, 4'(ex), 3'(f - 8)};
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // out_ready pattern: 0 = always ready, 1 = random, 2 = held low
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   w;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.a_operand = a;
    bus.b_operand = b;
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      w++;
      if (w > 200) begin
        $display("FAIL send_timeout: in_ready never rose, got 0 required 1");
        $fatal(1, "send timeout");
      end
    end
    e = model(a, b);
    e.acc = cyc;
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Monitor/scoreboard: sole owner of the comparison counters.
  initial begin
    exp_t e;
    bit   prev_ov;
    bit   prev_rst;
    int   drain;
    prev_ov  = 1'b0;
    prev_rst = 1'b1;
    drain    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_result",    32'(bus.result),    32'd0);
        chk("rst_flags",     32'({bus.Exception, bus.Overflow, bus.Underflow, bus.DivByZero}), 32'd0);
        prev_ov = 1'b0;
      end else begin
        if (prev_rst) chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
          end else begin
            e = q[0];
            chk("result",    32'(bus.result),    32'(e.res));
            chk("Exception", 32'(bus.Exception), 32'(e.exc));
            chk("Overflow",  32'(bus.Overflow),  32'(e.ovf));
            chk("Underflow", 32'(bus.Underflow), 32'(e.unf));
            chk("DivByZero", 32'(bus.DivByZero), 32'(e.dbz));
            chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
            if (!prev_ov) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            if (bus.out_ready) void'(q.pop_front());
          end
        end
        prev_ov = bus.out_valid;
      end
      prev_rst = rst;
      if (stim_done) begin
        drain++;
        if (q.size() == 0 && !bus.out_valid) begin
          $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
          $finish;
        end else if (drain > 300) begin
          chk("drain_pending", 32'(q.size()), 32'd0);
          $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
          $finish;
        end
      end
    end
  end

  initial begin
    int w;
    cyc           = 0;
    n_checks      = 0;
    n_fail        = 0;
    rdy_mode      = 0;
    stim_done     = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a_operand = 8'h00;
    bus.b_operand = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    send(8'h44, 8'h40);
    send(8'h38, 8'h44);
    send(8'hF0, 8'h08);
    send(8'h08, 8'h70);
    send(8'h38, 8'h00);
    send(8'h7A, 8'h38);
    send(8'h00, 8'h00);
    send(8'h00, 8'h44);
    send(8'hBF, 8'h39);

    // Backpressure: result held for several cycles while a second operand waits.
    rdy_mode = 2;
    fork
      begin
        repeat (16) @(posedge clk);
        rdy_mode = 0;
      end
    join_none
    send(8'h44, 8'h40);
    send(8'h38, 8'h44);

    // Asynchronous reset during the third DIV cycle.
    w = 0;
    while (!(q.size() == 0 && bus.in_ready && !bus.out_valid)) begin
      @(negedge clk);
      w++;
      if (w > 200) begin
        $display("FAIL idle_timeout: divider never idle, got busy required idle");
        $fatal(1, "idle timeout");
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.a_operand = 8'h44;
    bus.b_operand = 8'h40;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h44, 8'h40);

    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rdy_mode  = 0;
    stim_done = 1'b1;
  end
endmodule
